nois_system_sysid_checker: RTL and testbench
============================================

// Module: nois_system_sysid_checker
// PURPOSE
//  Avalon-MM read master that sequences the system-ID slave after reset: reads ID word (addr 0),
//  then timestamp word (addr 1), compares both against expected values, and reports pass/fail.
//  Sits between the sysid slave and board-level status logic (LED/boot gating); also re-runs on request.
// PARAMETERS
//  EXPECTED_ID        32'd0           value required at address 0
//  EXPECTED_TS        32'd1416282964  value required at address 1
//  CHECK_TS           1               1: timestamp mismatch is a failure; 0: timestamp captured only
//  START_DELAY        16              cycles in WAIT after reset release / recheck before first read (>=1)
//  TIMEOUT_CYCLES     255             max cycles a read may be held off by waitrequest (>=1)
// PORTS
//  clock            in   1   system clock
//  reset_n          in   1   asynchronous active-low reset
//  recheck          in   1   pulse: restart sequence; honoured only in PASS/FAIL
//  avm_address      out  1   0 = ID word, 1 = timestamp word
//  avm_read         out  1   read strobe, held until accepted
//  avm_readdata     in   32  read data, valid when avm_read & !avm_waitrequest
//  avm_waitrequest  in   1   slave stall
//  busy             out  1   high in WAIT/RD_ID/RD_TS
//  done             out  1   high in PASS/FAIL
//  pass             out  1   high in PASS only
//  err_code         out  2   00 none, 01 ID mismatch, 10 TS mismatch, 11 timeout
//  id_value         out  32  captured ID word
//  ts_value         out  32  captured timestamp word
// BEHAVIOUR
//  - Reset (async assert, sync release): state=WAIT, delay/timeout counters=0, avm_read=0,
//    avm_address=0, pass=0, done=0, err_code=00, id_value=0, ts_value=0; busy=1.
//  - States: WAIT, RD_ID, RD_TS, PASS, FAIL. All outputs registered.
//  - WAIT: count START_DELAY cycles, then -> RD_ID with avm_read=1, avm_address=0, timeout cnt=0.
//  - RD_ID: each cycle avm_read & avm_waitrequest -> timeout cnt++; when cnt reaches TIMEOUT_CYCLES
//    -> FAIL, err=11, avm_read=0. On avm_read & !avm_waitrequest: capture id_value;
//    mismatch -> FAIL err=01; match -> RD_TS, avm_address=1, avm_read stays 1, timeout cnt=0.
//  - RD_TS: same timeout rule (err=11). On accept: capture ts_value, avm_read=0;
//    mismatch & CHECK_TS -> FAIL err=10; else -> PASS err=00.
//  - Accept with zero wait states: one read per cycle; first read issued cycle START_DELAY+1
//    after reset release, PASS asserted the cycle after the second accept (2 read cycles total).
//  - Accept and timeout in same cycle: accept wins.
//  - avm_address/avm_read never change while avm_read & avm_waitrequest (Avalon hold rule).
//  - PASS/FAIL: avm_read=0; outputs stable. recheck -> WAIT, clear pass/done/err_code,
//    keep id_value/ts_value until recaptured. recheck in WAIT/RD_ID/RD_TS ignored.
//  - Counters saturate; no wrap. Timeout counter width = clog2(TIMEOUT_CYCLES+1).
//  - reset_n asserted mid-read: avm_read drops immediately (async), full restart on release.
// TESTING
//  1 Slave returns 0 / 1416282964, no waits -> PASS, err=00, done=1, avm_read high exactly 2 cycles.
//  2 ID returns 32'h1 -> FAIL, err=01, id_value=1, no address-1 read issued.
//  3 TS returns 0, CHECK_TS=1 -> FAIL err=10; same stimulus CHECK_TS=0 -> PASS, ts_value=0.
//  4 waitrequest held 3 cycles on each read -> PASS; address/read stable throughout stalls.
//  5 waitrequest stuck high, TIMEOUT_CYCLES=8 -> FAIL err=11 after 8 stalled cycles, avm_read=0.
//  6 recheck pulse in PASS -> busy=1, done=0, repeat sequence; recheck during RD_ID ignored;
//    reset_n low mid-RD_TS -> all outputs to reset values asynchronously.

Source files
------------

// File: rtl/nois_system_sysid_checker.sv
// Post-reset Avalon-MM read master for the system-ID slave: reads the ID word, then the
// timestamp word, compares both against expected values and reports a registered pass/fail status.
module nois_system_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'd0,
    parameter logic [31:0] EXPECTED_TS    = 32'd1416282964,
    parameter bit          CHECK_TS       = 1'b1,
    parameter int unsigned START_DELAY    = 16,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        recheck,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [1:0]  err_code,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);
    localparam int unsigned   DW       = $clog2(START_DELAY + 1);
    localparam int unsigned   TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [DW-1:0] DLY_LAST = DW'(START_DELAY - 1);
    localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT_CYCLES);

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ID      = 2'b01;
    localparam logic [1:0] ERR_TS      = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    typedef enum logic [2:0] {
        S_WAIT  = 3'd0,
        S_RD_ID = 3'd1,
        S_RD_TS = 3'd2,
        S_PASS  = 3'd3,
        S_FAIL  = 3'd4
    } state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] dly_q, dly_d;
    logic [TW-1:0] to_q, to_d;
    logic          read_q, read_d;
    logic          addr_q, addr_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          pass_q, pass_d;
    logic [1:0]    err_q, err_d;
    logic [31:0]   id_q, id_d;
    logic [31:0]   ts_q, ts_d;
    logic          accept;
    logic          stall;

    assign accept = read_q & ~avm_waitrequest;
    assign stall  = read_q & avm_waitrequest;

    always_comb begin
        state_d = state_q;
        dly_d   = dly_q;
        to_d    = to_q;
        read_d  = read_q;
        addr_d  = addr_q;
        err_d   = err_q;
        id_d    = id_q;
        ts_d    = ts_q;

        unique case (state_q)
            S_WAIT: begin
                if (dly_q == DLY_LAST) begin
                    state_d = S_RD_ID;
                    read_d  = 1'b1;
                    addr_d  = 1'b0;
                    to_d    = '0;
                end else begin
                    dly_d = dly_q + DW'(1);
                end
            end
            S_RD_ID, S_RD_TS: begin
                // Accept takes priority over a timeout landing in the same cycle.
                if (accept) begin
                    if (state_q == S_RD_ID) begin
                        id_d = avm_readdata;
                        if (avm_readdata != EXPECTED_ID) begin
                            state_d = S_FAIL;
                            read_d  = 1'b0;
                            err_d   = ERR_ID;
                        end else begin
                            state_d = S_RD_TS;
                            addr_d  = 1'b1;
                            to_d    = '0;
                        end
                    end else begin
                        ts_d   = avm_readdata;
                        read_d = 1'b0;
                        if (CHECK_TS && (avm_readdata != EXPECTED_TS)) begin
                            state_d = S_FAIL;
                            err_d   = ERR_TS;
                        end else begin
                            state_d = S_PASS;
                            err_d   = ERR_NONE;
                        end
                    end
                end else if (stall) begin
                    to_d = (to_q == TO_LIMIT) ? to_q : to_q + TW'(1);
                    if (to_d == TO_LIMIT) begin
                        state_d = S_FAIL;
                        read_d  = 1'b0;
                        err_d   = ERR_TIMEOUT;
                    end
                end
            end
            S_PASS, S_FAIL: begin
                read_d = 1'b0;
                if (recheck) begin
                    state_d = S_WAIT;
                    dly_d   = '0;
                    addr_d  = 1'b0;
                    err_d   = ERR_NONE;
                end
            end
            default: begin
                state_d = S_WAIT;
                dly_d   = '0;
                read_d  = 1'b0;
                addr_d  = 1'b0;
            end
        endcase

        busy_d = (state_d == S_WAIT) || (state_d == S_RD_ID) || (state_d == S_RD_TS);
        done_d = (state_d == S_PASS) || (state_d == S_FAIL);
        pass_d = (state_d == S_PASS);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_WAIT;
            dly_q   <= '0;
            to_q    <= '0;
            read_q  <= 1'b0;
            addr_q  <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= ERR_NONE;
            id_q    <= '0;
            ts_q    <= '0;
        end else begin
            state_q <= state_d;
            dly_q   <= dly_d;
            to_q    <= to_d;
            read_q  <= read_d;
            addr_q  <= addr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            id_q    <= id_d;
            ts_q    <= ts_d;
        end
    end

    assign avm_address = addr_q;
    assign avm_read    = read_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign err_code    = err_q;
    assign id_value    = id_q;
    assign ts_value    = ts_q;
endmodule

// File: tb/tb_nois_system_sysid_checker.sv
// Bench for nois_system_sysid_checker: two instances (timestamp checked / not checked) share one
// Avalon slave; a timeline model predicts every output each cycle, plus hand-computed literals.
module tb_nois_system_sysid_checker;
    localparam int unsigned START_DELAY = 4;
    localparam int unsigned TIMEOUT     = 8;
    localparam logic [31:0] EXP_ID      = 32'd0;
    localparam logic [31:0] EXP_TS      = 32'd1416282964;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b1;
    logic        recheck = 1'b0;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;

    logic [1:0]  a_read, a_addr, a_busy, a_done, a_pass;
    logic [1:0]  a_err [2];
    logic [31:0] a_id  [2];
    logic [31:0] a_ts  [2];

    logic [1:0]  e_read, e_addr, e_busy, e_done, e_pass;
    logic [1:0]  e_err [2];
    logic [31:0] e_id  [2];
    logic [31:0] e_ts  [2];

    logic [31:0] cfg_id    = EXP_ID;
    logic [31:0] cfg_ts    = EXP_TS;
    int unsigned cfg_waits = 0;
    logic        cfg_stuck = 1'b0;
    int unsigned stall_cnt = 0;
    int unsigned rd_cycles = 0;
    int unsigned a1_cycles = 0;

    int n_checks = 0;
    int n_errors = 0;

    nois_system_sysid_checker #(
        .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .CHECK_TS(1'b1),
        .START_DELAY(START_DELAY), .TIMEOUT_CYCLES(TIMEOUT)
    ) dut0 (
        .clock(clock), .reset_n(reset_n), .recheck(recheck),
        .avm_address(a_addr[0]), .avm_read(a_read[0]),
        .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
        .busy(a_busy[0]), .done(a_done[0]), .pass(a_pass[0]), .err_code(a_err[0]),
        .id_value(a_id[0]), .ts_value(a_ts[0])
    );

    nois_system_sysid_checker #(
        .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .CHECK_TS(1'b0),
        .START_DELAY(START_DELAY), .TIMEOUT_CYCLES(TIMEOUT)
    ) dut1 (
        .clock(clock), .reset_n(reset_n), .recheck(recheck),
        .avm_address(a_addr[1]), .avm_read(a_read[1]),
        .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
        .busy(a_busy[1]), .done(a_done[1]), .pass(a_pass[1]), .err_code(a_err[1]),
        .id_value(a_id[1]), .ts_value(a_ts[1])
    );

    always #5 clock = ~clock;

    // Slave: stalls each read for cfg_waits cycles, or forever when cfg_stuck.
    always_comb begin
        avm_waitrequest = cfg_stuck | (a_read[0] && (stall_cnt < cfg_waits));
        avm_readdata    = a_addr[0] ? cfg_ts : cfg_id;
    end

    always @(posedge clock) begin
        if (a_read[0] && avm_waitrequest) stall_cnt <= stall_cnt + 1;
        else stall_cnt <= 0;
        if (a_read[0]) rd_cycles <= rd_cycles + 1;
        if (a_read[0] && a_addr[0]) a1_cycles <= a1_cycles + 1;
    end

    task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s dut%0d at %0t: got 0x%08h, expected 0x%08h", name, k, $time, act, exp);
        end
    endtask

    // ---------------- timeline model ----------------
    task automatic step(output bit ab, output logic w, output logic [31:0] d, output logic rc);
        @(negedge clock);
        w  = avm_waitrequest;
        d  = avm_readdata;
        rc = recheck;
        @(posedge clock);
        ab = ~reset_n;
    endtask

    task automatic model_finish(input int k, input logic [1:0] code);
        e_read[k] = 1'b0;
        e_busy[k] = 1'b0;
        e_done[k] = 1'b1;
        e_pass[k] = (code == 2'b00);
        e_err[k]  = code;
    endtask

    // res: 0 accepted, 1 timed out, 2 reset seen
    task automatic model_read(input int k, input logic adr, output logic [31:0] data, output int res);
        bit          ab;
        logic        w, rc;
        logic [31:0] d;
        int unsigned stalls = 0;
        e_read[k] = 1'b1;
        e_addr[k] = adr;
        data = '0;
        res  = 2;
        forever begin
            step(ab, w, d, rc);
            if (ab) return;
            if (!w) begin
                data = d;
                res  = 0;
                return;
            end
            stalls++;
            if (stalls == TIMEOUT) begin
                res = 1;
                return;
            end
        end
    endtask

    task automatic model_run(input int k, output bit again);
        bit          ab;
        bit          chk_ts = (k == 0);
        logic        w, rc;
        logic [31:0] d;
        int          res;
        again = 1'b0;
        e_busy[k] = 1'b1; e_done[k] = 1'b0; e_pass[k] = 1'b0;
        e_err[k]  = 2'b00; e_read[k] = 1'b0; e_addr[k] = 1'b0;
        repeat (START_DELAY) begin
            step(ab, w, d, rc);
            if (ab) return;
        end
        model_read(k, 1'b0, d, res);
        if (res == 2) return;
        if (res == 1) model_finish(k, 2'b11);
        else begin
            e_id[k] = d;
            if (d != EXP_ID) model_finish(k, 2'b01);
            else begin
                model_read(k, 1'b1, d, res);
                if (res == 2) return;
                if (res == 1) model_finish(k, 2'b11);
                else begin
                    e_ts[k] = d;
                    if (chk_ts && d != EXP_TS) model_finish(k, 2'b10);
                    else model_finish(k, 2'b00);
                end
            end
        end
        forever begin
            step(ab, w, d, rc);
            if (ab) return;
            if (rc) begin
                again = 1'b1;
                return;
            end
        end
    endtask

    task automatic model_loop(input int k);
        bit again;
        forever begin
            e_busy[k] = 1'b1; e_done[k] = 1'b0; e_pass[k] = 1'b0; e_read[k] = 1'b0;
            e_addr[k] = 1'b0; e_err[k] = 2'b00; e_id[k] = '0; e_ts[k] = '0;
            wait (reset_n === 1'b1);
            do model_run(k, again); while (again);
        end
    endtask

    task automatic compare_loop();
        logic        pst = 1'b0, pr = 1'b0, pa = 1'b0, prst = 1'b0;
        logic        eb, ed, ep, er, ea;
        logic [1:0]  ee;
        logic [31:0] ei, et;
        forever begin
            @(negedge clock);
            for (int k = 0; k < 2; k++) begin
                if (reset_n) begin
                    eb = e_busy[k]; ed = e_done[k]; ep = e_pass[k]; er = e_read[k]; ea = e_addr[k];
                    ee = e_err[k]; ei = e_id[k]; et = e_ts[k];
                end else begin
                    eb = 1'b1; ed = 1'b0; ep = 1'b0; er = 1'b0; ea = 1'b0;
                    ee = 2'b00; ei = '0; et = '0;
                end
                check("busy", k, 32'(a_busy[k]), 32'(eb));
                check("done", k, 32'(a_done[k]), 32'(ed));
                check("pass", k, 32'(a_pass[k]), 32'(ep));
                check("avm_read", k, 32'(a_read[k]), 32'(er));
                check("avm_address", k, 32'(a_addr[k]), 32'(ea));
                check("err_code", k, 32'(a_err[k]), 32'(ee));
                check("id_value", k, a_id[k], ei);
                check("ts_value", k, a_ts[k], et);
            end
            // Held bus during a stall; only a timeout may drop the strobe.
            if (reset_n && prst && pst && a_err[0] != 2'b11) begin
                check("hold_read", 0, 32'(a_read[0]), 32'(pr));
                check("hold_addr", 0, 32'(a_addr[0]), 32'(pa));
            end
            pst  = a_read[0] & avm_waitrequest;
            pr   = a_read[0];
            pa   = a_addr[0];
            prst = reset_n;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic pulse_recheck();
        @(posedge clock); #1 recheck = 1'b1;
        @(posedge clock); #1 recheck = 1'b0;
    endtask

    task automatic wait_done(input int maxc, output int n);
        n = 0;
        do begin
            @(posedge clock); #1;
            n++;
        end while (!a_done[0] && n < maxc);
        check("done_reached", 0, 32'(a_done[0]), 32'd1);
    endtask

    task automatic wait_read(input logic adr, input int maxc);
        int n = 0;
        while (!(a_read[0] && a_addr[0] == adr) && n < maxc) begin
            @(posedge clock); #1;
            n++;
        end
        check("read_reached", 0, 32'(a_read[0] && a_addr[0] == adr), 32'd1);
    endtask

    initial begin
        int          n;
        int unsigned r0, q0;
        reset_n = 1'b0;
        fork
            model_loop(0);
            model_loop(1);
            compare_loop();
            begin
                #200000;
                $display("FAIL watchdog: simulation did not complete");
                $fatal(1, "watchdog");
            end
        join_none

        repeat (3) @(posedge clock);
        #1;
        check("rst_busy", 0, 32'(a_busy[0]), 32'd1);
        check("rst_read", 0, 32'(a_read[0]), 32'd0);
        check("rst_done", 0, 32'(a_done[0]), 32'd0);
        reset_n = 1'b1;

        // 1: clean slave, no waits
        r0 = rd_cycles;
        wait_done(50, n);
        check("s1_latency", 0, 32'(n), 32'(START_DELAY + 2));
        check("s1_pass", 0, 32'(a_pass[0]), 32'd1);
        check("s1_err", 0, 32'(a_err[0]), 32'd0);
        check("s1_read_cycles", 0, 32'(rd_cycles - r0), 32'd2);
        check("s1_ts", 0, a_ts[0], 32'd1416282964);

        // 2: wrong ID
        cfg_id = 32'h1;
        q0 = a1_cycles;
        pulse_recheck();
        wait_done(50, n);
        check("s2_err", 0, 32'(a_err[0]), 32'd1);
        check("s2_id", 0, a_id[0], 32'h1);
        check("s2_pass", 0, 32'(a_pass[0]), 32'd0);
        check("s2_no_ts_read", 0, 32'(a1_cycles - q0), 32'd0);

        // 3: wrong timestamp, checked vs. capture-only
        cfg_id = EXP_ID;
        cfg_ts = 32'd0;
        pulse_recheck();
        wait_done(50, n);
        check("s3_err", 0, 32'(a_err[0]), 32'd2);
        check("s3_pass_nochk", 1, 32'(a_pass[1]), 32'd1);
        check("s3_err_nochk", 1, 32'(a_err[1]), 32'd0);
        check("s3_ts_nochk", 1, a_ts[1], 32'd0);

        // 4: three wait states per read
        cfg_ts = EXP_TS;
        cfg_waits = 3;
        r0 = rd_cycles;
        pulse_recheck();
        wait_done(60, n);
        check("s4_pass", 0, 32'(a_pass[0]), 32'd1);
        check("s4_read_cycles", 0, 32'(rd_cycles - r0), 32'd8);

        // 5: waitrequest stuck high
        cfg_stuck = 1'b1;
        r0 = rd_cycles;
        pulse_recheck();
        wait_done(60, n);
        check("s5_err", 0, 32'(a_err[0]), 32'd3);
        check("s5_read", 0, 32'(a_read[0]), 32'd0);
        check("s5_stall_cycles", 0, 32'(rd_cycles - r0), 32'(TIMEOUT));

        // 6a: recheck from FAIL, then a recheck during RD_ID must be ignored
        cfg_stuck = 1'b0;
        pulse_recheck();
        wait_read(1'b0, 20);
        pulse_recheck();
        check("s6_ignored_busy", 0, 32'(a_busy[0]), 32'd1);
        check("s6_ignored_read", 0, 32'(a_read[0]), 32'd1);
        check("s6_ignored_addr", 0, 32'(a_addr[0]), 32'd0);
        wait_done(60, n);
        check("s6_pass", 0, 32'(a_pass[0]), 32'd1);

        // 6b: recheck from PASS, then reset mid timestamp read
        pulse_recheck();
        check("s6_rechk_busy", 0, 32'(a_busy[0]), 32'd1);
        check("s6_rechk_done", 0, 32'(a_done[0]), 32'd0);
        check("s6_rechk_ts_kept", 0, a_ts[0], EXP_TS);
        wait_read(1'b1, 40);
        #2 reset_n = 1'b0;
        #1;
        check("s6_async_read", 0, 32'(a_read[0]), 32'd0);
        check("s6_async_addr", 0, 32'(a_addr[0]), 32'd0);
        check("s6_async_busy", 0, 32'(a_busy[0]), 32'd1);
        check("s6_async_ts", 0, a_ts[0], 32'd0);
        cfg_waits = 0;
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        wait_done(50, n);
        check("s6_restart_latency", 0, 32'(n), 32'(START_DELAY + 2));
        check("s6_restart_pass", 0, 32'(a_pass[0]), 32'd1);

        repeat (2) @(posedge clock);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
